// File: rtl/array_wr_arbiter.sv
// array_wr_arbiter
// Two write requesters (A, B) share one 2^AW x DW array through a round-robin
// arbiter. At most one write is granted per clock. A write is stored only if
// its data is below LIMIT. Writes at or above LIMIT are rejected and counted
// in a saturating counter.
// Per-entry valid bits make unwritten entries read back as 0. Because of this,
// every value that can be read is below LIMIT.
// Optional build macro: ARRAY_ARB_ASSERT_EN enables immediate assertions on the
// three output invariants.

module array_wr_arbiter #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int LIMIT = 200,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          rej,
  output logic [CW-1:0] rej_count,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [DW-1:0] LIMIT_V = DW'(LIMIT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t             pri_q;
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic          elig_a;
  logic          elig_b;
  logic          grant_a;
  logic          grant_b;
  logic          any_grant;
  logic          accept;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  // Pick the winner. A requester that is being acked this cycle sits out,
  // so it cannot be serviced twice for the same held request.
  always_comb begin
    elig_a    = req_a && !ack_a;
    elig_b    = req_b && !ack_b;
    grant_a   = elig_a && (!elig_b || (pri_q == PRI_A));
    grant_b   = elig_b && (!elig_a || (pri_q == PRI_B));
    any_grant = grant_a || grant_b;
    win_addr  = grant_b ? addr_b : addr_a;
    win_data  = grant_b ? data_b : data_a;
    accept    = any_grant && (win_data < LIMIT_V);
  end

  // Arbitration state: ack/rej pulses, round-robin pointer, reject counter, valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rej       <= 1'b0;
      rej_count <= '0;
      pri_q     <= PRI_A;
      valid_q   <= '0;
    end else begin
      ack_a <= grant_a;
      ack_b <= grant_b;
      rej   <= any_grant && !accept;
      if (grant_a) begin
        pri_q <= PRI_B;
      end else if (grant_b) begin
        pri_q <= PRI_A;
      end
      if (accept) begin
        valid_q[win_addr] <= 1'b1;
      end else if (any_grant && (rej_count != CNT_MAX)) begin
        rej_count <= rej_count + CW'(1);
      end
    end
  end

  // Array storage is not reset; the cleared valid bits hide any stale contents
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[win_addr] <= win_data;
    end
  end

  // Registered read that sees the array as it was before this edge's write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= valid_q[rd_addr] ? mem[rd_addr] : '0;
    end
  end

`ifdef ARRAY_ARB_ASSERT_EN
  // Output invariants that must hold on every cycle
  always @* begin
    a_rd_data_below_limit: assert (rd_data < LIMIT_V);
    a_acks_exclusive:      assert (!(ack_a && ack_b));
    a_rej_implies_ack:     assert (!rej || ack_a || ack_b);
  end
`endif

endmodule

// File: tb/tb_array_wr_arbiter.sv
// tb_array_wr_arbiter
// Directed scenarios with literal expectations, followed by randomized
// requester traffic. All outputs are compared every cycle against a
// behavioural model of the arbiter and array.

module tb_array_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic        req_b;
  logic [7:0]  addr_b;
  logic [31:0] data_b;
  logic        ack_a;
  logic        ack_b;
  logic        rej;
  logic [7:0]  rej_count;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;
  bit cmpOn = 0;

  // Behavioural model state
  bit          m_ack_a;
  bit          m_ack_b;
  bit          m_rej;
  int          m_cnt;
  bit          m_turn_b;
  logic [31:0] m_rd;
  logic [31:0] m_mem [256];
  bit          m_valid [256];

  array_wr_arbiter #(.AW(8), .DW(32), .LIMIT(200), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .rej(rej), .rej_count(rej_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Drives one set of inputs, lets one rising edge pass, and returns at the
  // next falling edge plus 1 time unit.
  task automatic applyStimulus(input bit ra, input logic [7:0] aa, input logic [31:0] da,
                               input bit rb, input logic [7:0] ab, input logic [31:0] db,
                               input logic [7:0] ra_rd);
    req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    rd_addr = ra_rd;
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] pickData();
    case ($urandom_range(0, 4))
      0: pickData = 32'(197 + $urandom_range(0, 5));
      1: pickData = 32'hFFFF_FFFF;
      default: pickData = 32'($urandom_range(0, 255));
    endcase
  endfunction

  // Reference model: one winner per edge, round-robin on ties, acked
  // requesters ineligible, data below 200 stored, others counted up to 255.
  always @(posedge clk or posedge rst) begin
    int          win;
    bit          ea;
    bit          eb;
    logic [7:0]  wa;
    logic [31:0] wd;
    if (rst) begin
      m_ack_a = 0; m_ack_b = 0; m_rej = 0; m_cnt = 0; m_turn_b = 0; m_rd = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else begin
      m_rd = m_valid[rd_addr] ? m_mem[rd_addr] : 32'd0;
      ea = req_a && !m_ack_a;
      eb = req_b && !m_ack_b;
      if (ea && eb) win = m_turn_b ? 2 : 1;
      else if (ea)  win = 1;
      else if (eb)  win = 2;
      else          win = 0;
      m_ack_a = (win == 1);
      m_ack_b = (win == 2);
      m_rej   = 0;
      if (win != 0) begin
        wa = (win == 1) ? addr_a : addr_b;
        wd = (win == 1) ? data_a : data_b;
        m_turn_b = (win == 1);
        if (wd < 32'd200) begin
          m_mem[wa]   = wd;
          m_valid[wa] = 1;
        end else begin
          m_rej = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model plus invariants
  always @(negedge clk) begin
    if (cmpOn && !rst) begin
      checkOutput("ack_a", 32'(ack_a), 32'(m_ack_a));
      checkOutput("ack_b", 32'(ack_b), 32'(m_ack_b));
      checkOutput("rej", 32'(rej), 32'(m_rej));
      checkOutput("rej_count", 32'(rej_count), 32'(m_cnt));
      checkOutput("rd_data", rd_data, m_rd);
      checkOutput("rd_below_limit", 32'(rd_data < 32'd200), 32'd1);
      checkOutput("acks_exclusive", 32'(ack_a && ack_b), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 0; addr_a = 0; data_a = 0;
    req_b = 0; addr_b = 0; data_b = 0;
    rd_addr = 8'h10;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    cmpOn = 1;

    // Reset state and read of an unwritten entry
    checkOutput("reset_ack_a", 32'(ack_a), 32'd0);
    checkOutput("reset_ack_b", 32'(ack_b), 32'd0);
    checkOutput("reset_rej_count", 32'(rej_count), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h10);
    checkOutput("reset_rd_0x10", rd_data, 32'd0);

    // Single accepted write from A
    applyStimulus(1, 8'h10, 150, 0, 0, 0, 8'h10);
    checkOutput("a_write_ack", 32'(ack_a), 32'd1);
    checkOutput("a_write_rej", 32'(rej), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h10);
    checkOutput("a_write_rd", rd_data, 32'd150);
    checkOutput("model_pin_rd150", m_rd, 32'd150);

    // Boundary value 200 rejected, 199 accepted
    applyStimulus(0, 0, 0, 1, 8'h20, 200, 8'h20);
    checkOutput("b_rej_ack", 32'(ack_b), 32'd1);
    checkOutput("b_rej_pulse", 32'(rej), 32'd1);
    checkOutput("b_rej_count", 32'(rej_count), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h20);
    checkOutput("b_rej_rd", rd_data, 32'd0);
    checkOutput("b_rej_pulse_end", 32'(rej), 32'd0);
    applyStimulus(0, 0, 0, 1, 8'h20, 199, 8'h20);
    checkOutput("b_199_ack", 32'(ack_b), 32'd1);
    checkOutput("b_199_rej", 32'(rej), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h20);
    checkOutput("b_199_rd", rd_data, 32'd199);

    // Both held on the same address: grants alternate starting with A
    rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 8'h30, 5, 1, 8'h30, 7, 8'h30);
      checkOutput("alt_ack_a", 32'(ack_a), 32'((i % 2) == 0));
      checkOutput("alt_ack_b", 32'(ack_b), 32'((i % 2) == 1));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h30);
    checkOutput("alt_final_rd", rd_data, 32'd7);

    // Read-before-write at the same edge
    applyStimulus(1, 8'h40, 1, 0, 0, 0, 8'h40);
    checkOutput("rbw_first_ack", 32'(ack_a), 32'd1);
    applyStimulus(0, 0, 0, 1, 8'h40, 2, 8'h40);
    checkOutput("rbw_old_value", rd_data, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h40);
    checkOutput("rbw_new_value", rd_data, 32'd2);

    // Saturation of the reject counter, then reset in the middle of a request
    applyStimulus(1, 8'h10, 77, 0, 0, 0, 8'h10);
    checkOutput("sat_pre_write_ack", 32'(ack_a), 32'd1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 8'h50, 32'hFFFF_FFFF, 1, 8'h51, 32'hFFFF_FFFF, 8'h10);
    end
    checkOutput("sat_count", 32'(rej_count), 32'd255);
    checkOutput("model_pin_sat", 32'(m_cnt), 32'd255);
    checkOutput("sat_rd_0x10", rd_data, 32'd77);
    rst = 1'b1;
    #1;
    checkOutput("midreq_rst_ack_a", 32'(ack_a), 32'd0);
    checkOutput("midreq_rst_ack_b", 32'(ack_b), 32'd0);
    checkOutput("midreq_rst_count", 32'(rej_count), 32'd0);
    checkOutput("midreq_rst_rd", rd_data, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h10);
    checkOutput("post_rst_rd_0x10", rd_data, 32'd0);

    // Randomized requester traffic following the hold-until-ack protocol
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        req_a = 0; req_b = 0;
        @(negedge clk); #1 rst = 1'b0;
      end else begin
        if (!req_a || m_ack_a) begin
          req_a  = ($urandom_range(0, 2) != 0);
          addr_a = 8'($urandom_range(0, 15));
          data_a = pickData();
        end
        if (!req_b || m_ack_b) begin
          req_b  = ($urandom_range(0, 2) != 0);
          addr_b = 8'($urandom_range(0, 15));
          data_b = pickData();
        end
        rd_addr = 8'($urandom_range(0, 15));
        @(negedge clk); #1;
      end
    end

    cmpOn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
